// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state, machine word and arbiter grant state.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    // ERROR ends an access exactly like ACCESS does; only the sticky flag differs.
    function automatic logic ram_done(input ramstate_t rs);
        return (rs == ACCESS) || (rs == ERROR);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; flags when the ceiling is reached.
module sat_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MAX   = 255
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic inc,
    output logic at_max
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + WIDTH'(1);
        end
    end

    assign at_max = (count == WIDTH'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between fetch (I) and data (D): data priority, fetch starvation
// guard, per-access timeout and a sticky error flag.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              err
);

    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
    localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);

    arb_state_t        state;
    ramstate_t         rs;
    logic              granted_c;
    logic              req_c;
    logic              abort_c;
    logic              done_c;
    logic              tmo_c;
    logic              fin_c;
    logic              go_d_c;
    logic              go_i_c;
    logic              starve_max;
    logic              starve_inc;
    logic              starve_clr;
    logic              tmo_max;
    logic              tmo_inc;
    logic              tmo_clr;
    logic              err_q;
    logic [DATA_W-1:0] load_c;
    logic [DATA_W-1:0] iload_q;
    logic [DATA_W-1:0] dload_q;

    assign rs = ramstate_t'(ramstate);

    // Grant events: abort on flush, finish on ACCESS/ERROR or timeout, arbitration in IDLE.
    always_comb begin
        req_c = 1'b0;
        case (state)
            GNT_I:   req_c = iREN;
            GNT_D:   req_c = dREN | dWEN;
            default: req_c = 1'b0;
        endcase
        granted_c  = (state != IDLE);
        abort_c    = granted_c && !req_c;
        done_c     = granted_c && req_c && ram_done(rs);
        tmo_c      = granted_c && req_c && !ram_done(rs) && tmo_max;
        fin_c      = done_c || tmo_c;
        go_d_c     = (state == IDLE) && (dREN || dWEN) && !(iREN && starve_max);
        go_i_c     = (state == IDLE) && !go_d_c && iREN;
        starve_inc = go_d_c && iREN;
        starve_clr = (go_d_c && !iREN) || go_i_c;
        tmo_inc    = granted_c && req_c && !ram_done(rs);
        tmo_clr    = !granted_c || abort_c || fin_c;
        load_c     = done_c ? ramload : '0;
    end

    sat_counter #(
        .WIDTH (STARVE_W),
        .MAX   (STARVE_MAX)
    ) u_starve (
        .CLK    (CLK),
        .nRST   (nRST),
        .clear  (starve_clr),
        .inc    (starve_inc),
        .at_max (starve_max)
    );

    sat_counter #(
        .WIDTH (TMO_W),
        .MAX   (TIMEOUT)
    ) u_timeout (
        .CLK    (CLK),
        .nRST   (nRST),
        .clear  (tmo_clr),
        .inc    (tmo_inc),
        .at_max (tmo_max)
    );

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state   <= IDLE;
            err_q   <= 1'b0;
            iload_q <= '0;
            dload_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go_d_c) begin
                        state <= GNT_D;
                    end else if (go_i_c) begin
                        state <= GNT_I;
                    end
                end
                GNT_I, GNT_D: begin
                    if (abort_c || fin_c) begin
                        state <= IDLE;
                    end
                    if (fin_c) begin
                        if (state == GNT_I) begin
                            iload_q <= load_c;
                        end else begin
                            dload_q <= load_c;
                        end
                    end
                    if (tmo_c || (done_c && (rs == ERROR))) begin
                        err_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM side follows the granted requester's live inputs; a write wins over a read.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            GNT_I: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
            end
            GNT_D: begin
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            default: ;
        endcase
    end

    assign iwait = !((state == GNT_I) && fin_c);
    assign dwait = !((state == GNT_D) && fin_c);
    assign iload = ((state == GNT_I) && fin_c) ? load_c : iload_q;
    assign dload = ((state == GNT_D) && fin_c) ? load_c : dload_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a cycle-level behavioural model.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SM = 4;
    localparam int unsigned TO = 255;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic          iwait;
    logic [DW-1:0] iload;
    logic          dREN;
    logic          dWEN;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dstore;
    logic          dwait;
    logic [DW-1:0] dload;
    logic          ramREN;
    logic          ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore;
    logic [DW-1:0] ramload;
    logic [1:0]    ramstate;
    logic          err;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SM),
        .TIMEOUT    (TO)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .err      (err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit done_run = 0;

    // Behavioural model: owner 0 = nobody, 1 = fetch, 2 = data.
    int            owner;
    int            starve;
    int            timer;
    bit            m_err;
    logic [DW-1:0] m_iload;
    logic [DW-1:0] m_dload;
    int            wait_log[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner   = 0;
        starve  = 0;
        timer   = 0;
        m_err   = 0;
        m_iload = '0;
        m_dload = '0;
    endtask

    // Entered at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        bit            req;
        bit            fin_ok;
        bit            fin_tmo;
        int            rs;
        logic          e_ren;
        logic          e_wen;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_store;
        logic [DW-1:0] e_val;
        #1;
        rs      = int'(ramstate);
        req     = (owner == 1) ? iREN : (owner == 2) ? (dREN | dWEN) : 1'b0;
        fin_ok  = (owner != 0) && req && (rs == 2 || rs == 3);
        fin_tmo = (owner != 0) && req && !fin_ok && (timer == int'(TO));
        e_val   = fin_ok ? ramload : '0;
        e_ren   = (owner == 1) ? 1'b1 : (owner == 2) ? (dREN & ~dWEN) : 1'b0;
        e_wen   = (owner == 2) ? dWEN : 1'b0;
        e_addr  = (owner == 1) ? iaddr : (owner == 2) ? daddr : '0;
        e_store = (owner == 2) ? dstore : '0;
        check_eq("ramREN", 64'(ramREN), 64'(e_ren));
        check_eq("ramWEN", 64'(ramWEN), 64'(e_wen));
        check_eq("ramaddr", 64'(ramaddr), 64'(e_addr));
        check_eq("ramstore", 64'(ramstore), 64'(e_store));
        check_eq("iwait", 64'(iwait), 64'(!(owner == 1 && (fin_ok || fin_tmo))));
        check_eq("dwait", 64'(dwait), 64'(!(owner == 2 && (fin_ok || fin_tmo))));
        check_eq("iload", 64'(iload), 64'((owner == 1 && (fin_ok || fin_tmo)) ? e_val : m_iload));
        check_eq("dload", 64'(dload), 64'((owner == 2 && (fin_ok || fin_tmo)) ? e_val : m_dload));
        check_eq("err", 64'(err), 64'(m_err));
        if (iwait === 1'b0) wait_log.push_back(1);
        if (dwait === 1'b0) wait_log.push_back(2);
        @(posedge CLK);
        if (owner == 0) begin
            timer = 0;
            if ((dREN || dWEN) && !(iREN && starve == int'(SM))) begin
                owner  = 2;
                starve = iREN ? ((starve < int'(SM)) ? starve + 1 : int'(SM)) : 0;
            end else if (iREN) begin
                owner  = 1;
                starve = 0;
            end
        end else if (!req) begin
            owner = 0;
            timer = 0;
        end else if (fin_ok || fin_tmo) begin
            if (owner == 1) m_iload = e_val;
            else            m_dload = e_val;
            if (fin_tmo || rs == 3) m_err = 1;
            owner = 0;
            timer = 0;
        end else if (timer < int'(TO)) begin
            timer = timer + 1;
        end
        @(negedge CLK);
    endtask

    // Asynchronous reset pulse landing mid-cycle; entered and left at a falling edge.
    task automatic async_reset();
        #2 nRST = 1'b1;
        #1;
        check_eq("rst_ramREN", 64'(ramREN), 64'(0));
        check_eq("rst_ramWEN", 64'(ramWEN), 64'(0));
        check_eq("rst_dwait", 64'(dwait), 64'(1));
        check_eq("rst_iwait", 64'(iwait), 64'(1));
        check_eq("rst_err", 64'(err), 64'(0));
        model_reset();
        @(negedge CLK);
        nRST = 1'b0;
    endtask

    task automatic idle_inputs();
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        ramstate = 2'd0;
    endtask

    initial begin
        int exp_order[6] = '{2, 2, 2, 2, 1, 2};
        int gcyc;
        bit seen;

        nRST = 1'b1;
        idle_inputs();
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
        model_reset();
        repeat (2) @(negedge CLK);
        #1;
        check_eq("reset_iwait", 64'(iwait), 64'(1));
        check_eq("reset_dwait", 64'(dwait), 64'(1));
        check_eq("reset_iload", 64'(iload), 64'(0));
        check_eq("reset_dload", 64'(dload), 64'(0));
        check_eq("reset_ramREN", 64'(ramREN), 64'(0));
        check_eq("reset_ramaddr", 64'(ramaddr), 64'(0));
        check_eq("reset_err", 64'(err), 64'(0));
        @(negedge CLK);
        nRST = 1'b0;
        cycle();

        // Lone fetch with two BUSY cycles before ACCESS.
        wait_log.delete();
        iREN = 1'b1; iaddr = 32'h40; ramstate = 2'd0;
        cycle();
        ramstate = 2'd1;
        cycle();
        cycle();
        ramstate = 2'd2; ramload = 32'h8C01_0004;
        cycle();
        idle_inputs();
        cycle();
        check_eq("fetch_iload", 64'(iload), 64'(32'h8C01_0004));
        check_eq("fetch_pulses", 64'(wait_log.size()), 64'(1));

        // Fetch and data both pending: D first, I forced after four D grants.
        wait_log.delete();
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h80; daddr = 32'h200; ramstate = 2'd2;
        for (int k = 0; k < 14; k++) begin
            ramload = $urandom;
            cycle();
        end
        check_eq("order_len", 64'(wait_log.size() >= 6), 64'(1));
        for (int k = 0; k < 6 && k < wait_log.size(); k++)
            check_eq($sformatf("order_%0d", k), 64'(wait_log[k]), 64'(exp_order[k]));
        idle_inputs();
        cycle();

        // Write wins over read.
        wait_log.delete();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
        ramstate = 2'd1; ramload = 32'hCAFE_0001;
        cycle();
        #1;
        check_eq("ww_ramWEN", 64'(ramWEN), 64'(1));
        check_eq("ww_ramREN", 64'(ramREN), 64'(0));
        check_eq("ww_ramstore", 64'(ramstore), 64'(32'hDEAD_BEEF));
        check_eq("ww_ramaddr", 64'(ramaddr), 64'(32'h100));
        cycle();
        ramstate = 2'd2;
        cycle();
        idle_inputs();
        cycle();
        check_eq("ww_pulses", 64'(wait_log.size()), 64'(1));
        check_eq("ww_dload", 64'(dload), 64'(32'hCAFE_0001));

        // Fetch flushed after one granted cycle.
        wait_log.delete();
        iREN = 1'b1; iaddr = 32'h44; ramstate = 2'd1;
        cycle();
        cycle();
        iREN = 1'b0;
        cycle();
        #1;
        check_eq("flush_ramREN", 64'(ramREN), 64'(0));
        cycle();
        check_eq("flush_pulses", 64'(wait_log.size()), 64'(0));
        check_eq("flush_err", 64'(err), 64'(0));

        // RAM stuck BUSY: timeout ends the data access with zero data and sets err.
        dREN = 1'b1; daddr = 32'h300; ramstate = 2'd1;
        cycle();
        gcyc = 0;
        seen = 0;
        while (!seen && gcyc < 300) begin
            #1;
            if (dwait === 1'b0) begin
                seen = 1;
                check_eq("tmo_dload", 64'(dload), 64'(0));
            end
            gcyc++;
            cycle();
        end
        check_eq("tmo_seen", 64'(seen), 64'(1));
        check_eq("tmo_cycles", 64'(gcyc), 64'(TO + 1));
        idle_inputs();
        cycle();
        check_eq("tmo_err", 64'(err), 64'(1));
        repeat (5) cycle();
        check_eq("tmo_err_sticky", 64'(err), 64'(1));

        // Reset in the middle of a data grant.
        dREN = 1'b1; daddr = 32'h500; ramstate = 2'd1;
        cycle();
        cycle();
        async_reset();
        idle_inputs();
        cycle();
        check_eq("post_rst_err", 64'(err), 64'(0));

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            int r;
            if ($urandom_range(0, 3) == 0) iREN = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) dREN = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) dWEN = 1'($urandom_range(0, 3) == 0);
            iaddr   = $urandom;
            daddr   = $urandom;
            dstore  = $urandom;
            ramload = $urandom;
            r = int'($urandom_range(0, 19));
            ramstate = (r < 8) ? 2'd2 : (r < 16) ? 2'd1 : (r < 19) ? 2'd0 : 2'd3;
            if ($urandom_range(0, 499) == 0) async_reset();
            else                             cycle();
        end

        done_run = 1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        if (!done_run) begin
            n_tests++;
            n_fail++;
            $display("FAIL watchdog: got timeout expected run completion");
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared RAM port between the pipeline's instruction-fetch port (I) and data port (D).
- Sits between the pipeline and ram, in place of a direct memREN/memWEN hookup.
- Grants one requester at a time and holds the grant until ram reports completion.
- Uses data-priority arbitration with a starvation guard for fetches, plus a per-access timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, word width.
- STARVE_MAX, 4, consecutive D grants allowed while iREN is pending before I is forced.
- TIMEOUT, 255, maximum grant cycles without ACCESS before abort; fits an 8-bit counter.

Ports:
- CLK  in  1  system clock.
- nRST  in  1  asynchronous reset, active-high (asserted = 1).
- iREN  in  1  fetch request.
- iaddr  in  ADDR_W  fetch address.
- iwait  out  1  high until the fetch completes.
- iload  out  DATA_W  fetched word.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- dwait  out  1  high until the data access completes.
- dload  out  DATA_W  read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- err  out  1  sticky error flag.

Behaviour:
- Reset (nRST=1, asynchronous):
  - state=IDLE.
  - ramREN=ramWEN=0, ramaddr=0, ramstore=0.
  - iwait=dwait=1, iload=dload=0, err=0.
  - Starvation and timeout counters = 0.
  - Reset mid-grant aborts immediately; no completion is reported.
- States: IDLE, GNT_I, GNT_D. State is registered; ram outputs are combinational from the state and the granted requester's inputs.
- IDLE:
  - All ram outputs are 0.
  - Decision each cycle:
    - If (dREN|dWEN) and not (iREN and starve==STARVE_MAX): go to GNT_D.
    - Else if iREN: go to GNT_I.
    - Else: stay in IDLE.
  - Going to GNT_D while iREN is high: starve++ (saturates at STARVE_MAX).
  - Going to GNT_D while iREN is low: starve=0.
  - Going to GNT_I: starve=0.
- GNT_I:
  - ramREN=1, ramaddr=iaddr.
  - ramWEN=0, ramstore=0.
- GNT_D:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN; ramREN=dREN & ~dWEN, so the write wins if both are asserted.
- Completion: in GNT_x with ramstate==ACCESS:
  - xwait=0 for exactly that cycle; xload=ramload for that cycle.
  - Next state = IDLE.
  - Minimum latency: request to wait-low is 2 cycles (decision cycle + ACCESS cycle).
- wait outputs: iwait/dwait are 1 in every other cycle, including IDLE.
- iload/dload: hold their last completed value.
- Abort: the granted requester drops its request (flush) while in GNT_x:
  - Return to IDLE next cycle; no wait-low pulse.
  - Timeout counter clears.
- ERROR: ramstate==ERROR in GNT_x:
  - Treated as a completion: xwait=0, xload=ramload.
  - err is set to 1 and remains 1 until reset.
  - Return to IDLE.
- Timeout:
  - The counter increments each GNT_x cycle without ACCESS/ERROR.
  - When it reaches TIMEOUT: xwait=0, xload=0, err=1, go to IDLE.
  - The counter clears on every entry to IDLE.
- BUSY/FREE while granted: hold the grant and drive ram outputs unchanged.
- Requester inputs may change mid-grant. ramaddr follows them combinationally; the requester is responsible for holding them stable.
- No back-to-back grant without a pass through IDLE (one bubble cycle per access is accepted).

Decomposition:
- In cpu_types_pkg:
  - ramstate_t enum (FREE, BUSY, ACCESS, ERROR).
  - word_t.
  - Arbiter state enum arb_state_t (IDLE, GNT_I, GNT_D).
- Sub-module sat_counter, parameterised width/max, with clear/inc/at_max outputs. Instantiated twice: starvation counter and timeout counter.

Test Plan:
- Lone fetch: iREN=1, iaddr=0x40; ram gives BUSY×2 then ACCESS with ramload=0x8C010004.
  - Required: iwait low only in the ACCESS cycle; iload=0x8C010004; ramREN=1, ramaddr=0x40 during GNT_I.
- Simultaneous I and D: iREN=dREN=1.
  - Required: D granted first, dload returned; then I granted.
- Starvation guard (STARVE_MAX=4): iREN=1 and dREN=1 held continuously.
  - Required: after 4 D completions, the 5th grant goes to I; starve then resets.
- Write-wins: dREN=dWEN=1, daddr=0x100, dstore=0xDEADBEEF.
  - Required: ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait low on ACCESS.
- Flush and timeout:
  - iREN dropped after 1 GNT_I cycle. Required: IDLE next cycle, no iwait pulse, err=0.
  - Separately, ramstate stuck BUSY for 255 cycles. Required: dwait=0, dload=0, err=1, and err stays 1 until reset.
- Reset mid-grant: assert nRST during GNT_D.
  - Required: ramREN/ramWEN=0 immediately, dwait=1, err=0; after release, the arbiter is back in IDLE with counters cleared.
